// File: rtl/lc3b_types.sv
// Shared LC-3b widths, opcode encodings and the memory-stage FSM state type.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_nzp;
  typedef logic [39:0] lc3b_control;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldw  = 4'b0110,
    op_stw  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } mem_state_t;

  // Clears bit 0 using every input bit, so no operand bits are left dangling.
  function automatic lc3b_word word_align(input lc3b_word addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/gencc.sv
// Condition-code generator: {n,z,p} for a 16-bit result.
module gencc
  import lc3b_types::*;
(
  input  lc3b_word value,
  output lc3b_nzp  cc
);

  logic n_bit;
  logic z_bit;

  assign n_bit = value[15];
  assign z_bit = (value == 16'h0000);
  assign cc    = {n_bit, z_bit, ~n_bit & ~z_bit};

endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
module register #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory-access stage: drives the data-memory handshake (incl. LDI/STI
// two-access sequence), stalls upstream while busy and builds the mem_* bundle.
module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  lc3b_word    ex_ir,
  input  lc3b_word    ex_address,
  input  lc3b_word    ex_wdata,
  input  lc3b_word    ex_alu_out,
  input  lc3b_word    ex_next_instr,
  input  lc3b_control ex_control_sig,
  input  lc3b_reg     ex_dest,
  input  logic        dmem_resp,
  input  lc3b_word    dmem_rdata,
  output lc3b_word    dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output lc3b_word    dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        mem_stall,
  output logic        mem_valid,
  output lc3b_word    mem_address,
  output lc3b_word    mem_rdata,
  output lc3b_word    mem_alu_out,
  output lc3b_word    mem_ir,
  output lc3b_word    mem_next_instr,
  output lc3b_control mem_control_sig,
  output lc3b_reg     mem_dest,
  output lc3b_nzp     mem_cc
);

  mem_state_t state;
  mem_state_t state_next;
  logic       state_q;
  lc3b_word   ptr;
  logic       ptr_load;

  lc3b_opcode opcode;
  logic       op_is_load;
  logic       op_is_store;
  logic       op_is_indirect;
  logic       op_is_byte;
  logic       is_mem_op;
  logic       req;
  logic       in_second;
  logic       final_access;
  lc3b_word   cc_source;

  register #(.WIDTH(1)) state_reg (
    .clk   (clk),
    .reset (reset),
    .load  (1'b1),
    .d     (state_next),
    .q     (state_q)
  );
  assign state = mem_state_t'(state_q);

  register #(.WIDTH(16)) ptr_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ptr_load),
    .d     (dmem_rdata),
    .q     (ptr)
  );

  assign opcode         = lc3b_opcode'(ex_ir[15:12]);
  assign op_is_load     = (opcode == op_ldb) || (opcode == op_ldw) || (opcode == op_ldi);
  assign op_is_store    = (opcode == op_stb) || (opcode == op_stw) || (opcode == op_sti);
  assign op_is_indirect = (opcode == op_ldi) || (opcode == op_sti);
  assign op_is_byte     = (opcode == op_ldb) || (opcode == op_stb);
  assign is_mem_op      = ex_valid && (op_is_load || op_is_store);

  // Reset suppresses the request outright so a half-done indirect never writes.
  assign req = is_mem_op && !reset;

  // S_SECOND only means something while the indirect op is still presented;
  // otherwise the stage behaves as in S_FIRST and the FSM falls back.
  assign in_second    = (state == S_SECOND) && is_mem_op && op_is_indirect;
  assign final_access = !op_is_indirect || in_second;

  always_comb begin
    dmem_address     = word_align(ex_address);
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_wdata       = ex_wdata;
    dmem_byte_enable = 2'b11;
    state_next       = S_FIRST;
    ptr_load         = 1'b0;

    if (in_second) begin
      dmem_address = word_align(ptr);
    end else if (op_is_byte) begin
      dmem_address = ex_address;
    end

    if (req) begin
      // Indirect first access is always a pointer read, even for STI.
      dmem_read  = op_is_load || (op_is_indirect && !in_second);
      dmem_write = op_is_store && final_access;
    end

    if (opcode == op_stb) begin
      dmem_wdata       = {ex_wdata[7:0], ex_wdata[7:0]};
      dmem_byte_enable = ex_address[0] ? 2'b10 : 2'b01;
    end

    if (in_second) begin
      state_next = dmem_resp ? S_FIRST : S_SECOND;
    end else if (req && op_is_indirect && dmem_resp) begin
      state_next = S_SECOND;
      ptr_load   = 1'b1;
    end
  end

  assign mem_stall = req && !(dmem_resp && final_access);
  assign mem_valid = ex_valid && !mem_stall && !reset;

  always_comb begin
    mem_rdata = 16'h0000;
    unique case (opcode)
      op_ldb:         mem_rdata = ex_address[0] ? {8'h00, dmem_rdata[15:8]}
                                                : {8'h00, dmem_rdata[7:0]};
      op_ldw, op_ldi: mem_rdata = dmem_rdata;
      default:        mem_rdata = 16'h0000;
    endcase
  end

  assign cc_source = (ex_valid && op_is_load) ? mem_rdata : ex_alu_out;

  gencc cc_gen (
    .value (cc_source),
    .cc    (mem_cc)
  );

  assign mem_address     = dmem_address;
  assign mem_alu_out     = ex_alu_out;
  assign mem_ir          = ex_ir;
  assign mem_next_instr  = ex_next_instr;
  assign mem_control_sig = ex_control_sig;
  assign mem_dest        = ex_dest;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the LC-3b pipeline, between the EX/MEM pipeline register and the MEM/WB register (`wb_register`). It drives the single-ported data-memory handshake for LDB/LDW/LDI/STB/STW/STI, including the two-access indirect sequence. While an access is outstanding it freezes everything upstream and presents a bubble downstream. It produces the `mem_*` bundle, including load data and condition codes, that `wb_register` latches.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: EX/MEM slot holds a real instruction.
- `ex_ir` in 16: instruction; opcode is `ex_ir[15:12]`.
- `ex_address` in 16: effective address from EX.
- `ex_wdata` in 16: store source register value.
- `ex_alu_out`, `ex_next_instr` in 16 each: pass-through.
- `ex_control_sig` in 40 (`lc3b_control`): pass-through.
- `ex_dest` in 3 (`lc3b_reg`): pass-through.
- `dmem_resp` in 1: memory completed current request this cycle.
- `dmem_rdata` in 16: read data, valid with `dmem_resp`.
- `dmem_address` out 16: request address.
- `dmem_read`, `dmem_write` out 1 each: request strobes, mutually exclusive.
- `dmem_wdata` out 16: store data.
- `dmem_byte_enable` out 2: [1] high byte, [0] low byte.
- `mem_stall` out 1: hold PC/IF/ID/EX and EX/MEM registers.
- `mem_valid` out 1: slot delivered to `wb_register` is real.
- `mem_address`, `mem_rdata`, `mem_alu_out`, `mem_ir`, `mem_next_instr` out 16 each; `mem_control_sig` out 40; `mem_dest` out 3; `mem_cc` out 3 ({n,z,p}).

## Operation
- Memory op: `ex_valid` and opcode in {LDB 0010, LDW 0110, LDI 1010, STB 0011, STW 0111, STI 1011}. Any other valid instruction passes through with no request: `mem_valid`=1, `mem_stall`=0.
- FSM `mem_state_t` has two states, S_FIRST (reset) and S_SECOND. Register `ptr` is 16 bits and resets to 0.
- S_FIRST, direct op:
  - `dmem_address` is `ex_address` for bytes and `{ex_address[15:1],0}` for words.
  - Loads assert `dmem_read`; stores assert `dmem_write`.
  - Stays in S_FIRST.
- S_FIRST, LDI/STI: read word at `{ex_address[15:1],0}`. On `dmem_resp`, `ptr`<=`dmem_rdata` and go to S_SECOND.
- S_SECOND:
  - Address is `{ptr[15:1],0}`; LDI reads, STI writes.
  - On `dmem_resp`, go to S_FIRST.
- `mem_stall` = memory op and not (`dmem_resp` on final access). `mem_valid` = `ex_valid` and not `mem_stall`.
- Byte enables:
  - Word ops: 2'b11.
  - STB: 2'b10 if address[0] else 2'b01, with `dmem_wdata`={`ex_wdata[7:0]`,`ex_wdata[7:0]`}.
  - Reads: don't-care, driven 2'b11.
- `mem_rdata`:
  - LDB: zero-extended byte, high byte if address[0] else low.
  - LDW/LDI: `dmem_rdata`.
  - Otherwise: 0.
- `mem_cc` is taken from `mem_rdata` for loads and from `ex_alu_out` otherwise:
  - n = bit15.
  - z = value==0.
  - p = neither.
- `mem_address` = final access address (`ptr`-based for indirect). All other `mem_*` outputs are straight pass-through.

## Timing
- Outputs are combinational (Mealy) from EX/MEM inputs, state and `dmem_*`. Only state and `ptr` are registered.
- Direct op with `dmem_resp` at cycle k:
  - `mem_stall` is high in cycles before k and low at k.
  - `wb_register` captures the op at the k/k+1 edge.
  - Zero-wait memory completes in one cycle.
- Indirect op: at least 2 cycles. The final-access request first appears the cycle after the first `dmem_resp`.
- Strobes are held steady with a constant address until `dmem_resp`. Requests are never dropped mid-handshake except by reset.
- `dmem_resp` arriving with no request is ignored.
- Reset in any state: next state S_FIRST and `ptr`=0. During a reset cycle, `dmem_read`=`dmem_write`=0, `mem_stall`=0 and `mem_valid`=0. A mid-flight indirect is abandoned.
- `ex_valid`=0 in S_SECOND cannot occur while stalled. If it does, the FSM returns to S_FIRST next cycle with no request.

## Structure
- `lc3b_types` gains:
  - `lc3b_opcode` enum constants op_ldb/op_ldw/op_ldi/op_stb/op_stw/op_sti.
  - `mem_state_t` {S_FIRST, S_SECOND}.
- Reuse `register` for `ptr` and the state bit.
- One sub-module, `gencc`: 16-bit value in, 3-bit {n,z,p} out, combinational. It is shared with the writeback path.

## Test plan
- LDW addr 0x1235, mem[0x1234]=0x8001, resp after 3 cycles:
  - `dmem_address`=0x1234 with `mem_stall` high for 3 cycles.
  - Then `mem_rdata`=0x8001, `mem_cc`=100, `mem_valid`=1.
- LDB addr 0x2001, word 0xAB00, zero-wait:
  - Same cycle: `mem_rdata`=0x00AB, `mem_cc`=001.
- STB addr 0x3000, `ex_wdata`=0x12CD:
  - `dmem_wdata`=0xCDCD, `dmem_byte_enable`=01, `dmem_write`=1 until resp.
  - No read asserted.
- LDI addr 0x4000, mem[0x4000]=0x5000, mem[0x5000]=0x0000, 1-cycle resp each:
  - Read 0x4000, then read 0x5000.
  - `mem_address`=0x5000, `mem_cc`=010, stall for exactly 3 of 4 cycles.
- STI with reset asserted between the two accesses:
  - Strobes drop in the reset cycle; no write to the pointer target.
  - Next instruction ADD result 0x0007 passes with `mem_cc`=001 and no stall.
- Non-memory ADD, `ex_valid`=0 bubble, and a spurious `dmem_resp`:
  - No strobes; `mem_valid` follows `ex_valid`; state stays S_FIRST.
